// File: rtl/iob_iob2axi_read_burst.sv
// iob_iob2axi_read_burst: splits a word transfer into 4 KB-safe AXI4 INCR read bursts and streams the data out an IOb write port
module iob_iob2axi_read_burst #(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int XFER_LEN_W  = 16,
  parameter int MAX_BURST   = 16,
  parameter int AXI_ID_W    = 1,
  parameter int AXI_LEN_W   = 8,
  parameter int AXI_BURST_W = 2,
  parameter int AXI_LOCK_W  = 2,
  parameter int AXI_CACHE_W = 4,
  parameter int AXI_PROT_W  = 3,
  parameter int AXI_QOS_W   = 4
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   run_i,
  input  logic [ADDR_W-1:0]      addr_i,
  input  logic [XFER_LEN_W-1:0]  length_i,
  output logic                   ready_o,
  output logic                   error_o,
  output logic                   m_iob_valid_o,
  output logic [ADDR_W-1:0]      m_iob_addr_o,
  output logic [DATA_W-1:0]      m_iob_wdata_o,
  output logic [DATA_W/8-1:0]    m_iob_wstrb_o,
  input  logic                   m_iob_ready_i,
  output logic [AXI_ID_W-1:0]    m_axi_arid_o,
  output logic [ADDR_W-1:0]      m_axi_araddr_o,
  output logic [AXI_LEN_W-1:0]   m_axi_arlen_o,
  output logic [2:0]             m_axi_arsize_o,
  output logic [AXI_BURST_W-1:0] m_axi_arburst_o,
  output logic [AXI_LOCK_W-1:0]  m_axi_arlock_o,
  output logic [AXI_CACHE_W-1:0] m_axi_arcache_o,
  output logic [AXI_PROT_W-1:0]  m_axi_arprot_o,
  output logic [AXI_QOS_W-1:0]   m_axi_arqos_o,
  output logic                   m_axi_arvalid_o,
  input  logic                   m_axi_arready_i,
  input  logic [AXI_ID_W-1:0]    m_axi_rid_i,
  input  logic [DATA_W-1:0]      m_axi_rdata_i,
  input  logic [1:0]             m_axi_rresp_i,
  input  logic                   m_axi_rlast_i,
  input  logic                   m_axi_rvalid_i,
  output logic                   m_axi_rready_o
);
  localparam int BYTES = DATA_W / 8;
  localparam int SZ = $clog2(BYTES);
  typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;
  state_t state, state_nxt;
  logic [ADDR_W-1:0] start_addr, next_addr, cur_addr, araddr, h_addr, t_addr;
  logic [DATA_W-1:0] h_data, t_data;
  logic [XFER_LEN_W-1:0] remaining, rem_nxt;
  logic [AXI_LEN_W-1:0] arlen, beat;
  logic start, ar_fire, r_fire, pop, last_beat, error, v0, v1, unused_rid;

  // beats = min(remaining, MAX_BURST, words left in the 4 KB page), returned as arlen
  function automatic logic [AXI_LEN_W-1:0] burst_len(input logic [ADDR_W-1:0] a, input logic [XFER_LEN_W-1:0] r);
    logic [31:0] b, p;
    p = (32'd4096 - {20'd0, a[11:0]}) >> SZ;
    b = 32'(r);
    if (b > 32'(MAX_BURST)) b = 32'(MAX_BURST);
    if (b > p) b = p;
    return AXI_LEN_W'(b - 32'd1);
  endfunction

  assign start_addr = addr_i & ~ADDR_W'(BYTES - 1);
  assign next_addr = cur_addr + ADDR_W'(BYTES);
  assign start = state == IDLE && run_i && length_i != '0;
  assign ar_fire = m_axi_arvalid_o && m_axi_arready_i;
  assign r_fire = m_axi_rvalid_i && m_axi_rready_o;
  assign pop = v0 && m_iob_ready_i;
  assign last_beat = beat == arlen;
  assign rem_nxt = remaining - XFER_LEN_W'(arlen) - XFER_LEN_W'(1);
  assign unused_rid = ^m_axi_rid_i;

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: state_nxt = start ? ADDR : IDLE;
      ADDR: state_nxt = m_axi_arready_i ? DATA : ADDR;
      default:
        if (r_fire && last_beat && rem_nxt != '0) state_nxt = ADDR;
        else if (remaining == '0 && !v1 && (!v0 || pop)) state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) state <= IDLE;
    else state <= state_nxt;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cur_addr <= '0;
      araddr <= '0;
      arlen <= '0;
      remaining <= '0;
      beat <= '0;
      error <= 1'b0;
      v0 <= 1'b0;
      v1 <= 1'b0;
      h_addr <= '0;
      h_data <= '0;
      t_addr <= '0;
      t_data <= '0;
    end else begin
      if (state == IDLE && run_i) error <= 1'b0;
      if (start) begin
        cur_addr <= start_addr;
        araddr <= start_addr;
        remaining <= length_i;
        arlen <= burst_len(start_addr, length_i);
      end
      if (ar_fire) beat <= '0;
      if (r_fire) begin
        cur_addr <= next_addr;
        beat <= beat + AXI_LEN_W'(1);
        if (m_axi_rresp_i != 2'b00 || m_axi_rlast_i != last_beat) error <= 1'b1;
        if (last_beat) begin
          remaining <= rem_nxt;
          araddr <= next_addr;
          arlen <= burst_len(next_addr, rem_nxt);
        end
      end
      if (r_fire && (!v0 || (pop && !v1))) begin
        h_addr <= cur_addr;
        h_data <= m_axi_rdata_i;
      end else if (pop && v1) begin
        h_addr <= t_addr;
        h_data <= t_data;
      end
      if (r_fire && v0 && !pop) begin
        t_addr <= cur_addr;
        t_data <= m_axi_rdata_i;
      end
      v0 <= v0 ? (v1 || !pop || r_fire) : r_fire;
      v1 <= v1 ? !pop : (v0 && !pop && r_fire);
    end
  end

  assign ready_o = state == IDLE;
  assign error_o = error;
  assign m_iob_valid_o = v0;
  assign m_iob_addr_o = h_addr;
  assign m_iob_wdata_o = h_data;
  assign m_iob_wstrb_o = '1;
  assign m_axi_arid_o = '0;
  assign m_axi_araddr_o = araddr;
  assign m_axi_arlen_o = arlen;
  assign m_axi_arsize_o = 3'(SZ);
  assign m_axi_arburst_o = AXI_BURST_W'(1);
  assign m_axi_arlock_o = '0;
  assign m_axi_arcache_o = AXI_CACHE_W'(2);
  assign m_axi_arprot_o = AXI_PROT_W'(2);
  assign m_axi_arqos_o = '0;
  assign m_axi_arvalid_o = state == ADDR;
  assign m_axi_rready_o = state == DATA && remaining != '0 && !v1;
endmodule

// File: doc/iob_iob2axi_read_burst.md
# iob_iob2axi_read_burst

AXI4 read-burst engine that moves an arbitrary-length transfer from AXI memory into an IOb-native master write port. It is the parametrised successor of the single-burst IOb-to-AXI read block. It splits one request of up to 2^XFER_LEN_W-1 words into legal INCR bursts, capped at MAX_BURST beats and never crossing a 4 KB boundary. Data is buffered in a 2-entry skid buffer with registered IOb outputs, and a sticky per-transfer error is reported. It sits in the iob2axi bridge beside the write engine, driven by a DMA/control FSM.

## Interface
- ADDR_W, 32, AXI/IOb byte address width
- DATA_W, 32, data width; power of two, 8..1024
- XFER_LEN_W, 16, width of transfer length in words
- MAX_BURST, 16, max beats per burst; 1..2^AXI_LEN_W, power of two
- AXI_ID_W, 1; AXI_LEN_W, 8; AXI_BURST_W, 2; AXI_LOCK_W, 2; AXI_CACHE_W, 4; AXI_PROT_W, 3; AXI_QOS_W, 4: AXI field widths

Ports:
- clk_i  in  1  clock
- rst_i  in  1  reset, asynchronous, active-high
- run_i  in  1  start pulse; accepted only while ready_o=1
- addr_i  in  ADDR_W  start byte address; low log2(DATA_W/8) bits ignored (treated 0)
- length_i  in  XFER_LEN_W  transfer length in words; 0 = no-op
- ready_o  out  1  idle / transfer complete
- error_o  out  1  sticky error of last transfer
- m_iob_valid_o  out  1  data word valid
- m_iob_addr_o  out  ADDR_W  byte address of the word
- m_iob_wdata_o  out  DATA_W  read data
- m_iob_wstrb_o  out  DATA_W/8  constant all ones
- m_iob_ready_i  in  1  consumer accepts word
- m_axi_ar*: arid=0, araddr, arlen, arsize=log2(DATA_W/8), arburst=1 (INCR), arlock=0, arcache=2, arprot=2, arqos=0, arvalid out; arready in
- m_axi_r*: rid, rdata, rresp, rlast, rvalid in; rready out

## Operation
- States: IDLE, ADDR, DATA.
- IDLE:
  - ready_o=1.
  - On run_i with length_i≠0: latch aligned addr and remaining=length_i, clear error_o, compute burst, go ADDR.
  - On run_i with length_i=0: clear error_o, stay IDLE.
- Burst size: beats = min(remaining, MAX_BURST, (4096 - addr[11:0]) >> log2(DATA_W/8)); arlen = beats-1.
- ADDR:
  - arvalid=1; araddr/arlen are registered and stable until arready.
  - On arready go DATA; beat counter=0.
- DATA:
  - rready = skid buffer has ≥1 free entry.
  - On each rvalid&rready: push {rdata, cur_addr}; cur_addr += DATA_W/8; counter++.
  - Error conditions, each setting error_o (sticky): rresp≠0; rlast=1 on a non-final beat; rlast=0 on the final beat.
  - The block never terminates a burst early on error; it always consumes exactly arlen+1 beats.
- After the final beat of a burst, remaining -= beats:
  - remaining≠0: recompute burst, go ADDR.
  - otherwise: go IDLE once the skid buffer drains.
- Skid buffer: 2 entries. m_iob_valid_o/addr/wdata come from the head register. A word pops on m_iob_valid_o & m_iob_ready_i.
- run_i while ready_o=0 is ignored.
- rid is ignored (single ID).

## Timing
- Reset values: state=IDLE, ready_o=1, error_o=0, m_iob_valid_o=0, m_iob_addr_o=0, m_iob_wdata_o=0, arvalid=0, rready=0, araddr=0, arlen=0.
- run_i accepted at edge T: ready_o=0 and arvalid=1 from T+1.
- First R beat accepted at edge T: m_iob_valid_o=1 from T+1.
- With m_iob_ready_i held 1 and rvalid held 1, rready stays 1: one word per cycle with no bubbles within a burst.
- Between bursts: one cycle in ADDR, minimum, before the next AR handshake.
- ready_o rises the cycle after the last word pops. error_o is valid when ready_o rises and holds until the next accepted run_i.
- Consumer stall: rready drops the cycle after the buffer becomes full (2 words). No data loss, no duplication.
- rst_i mid-transfer: immediately returns to reset values. Outstanding AXI beats are not drained; the system must reset the slave too.

## Test plan
- Basic: addr=0x1000, length=4, DATA_W=32, m_iob_ready=1, OKAY responses -> one AR (araddr=0x1000, arlen=3, arsize=2); 4 words at m_iob_addr 0x1000..0x100C in 4 consecutive cycles; ready_o=1, error_o=0.
- Split by MAX_BURST: addr=0, length=40, MAX_BURST=16 -> ARs arlen=15 @0x0, 15 @0x40, 7 @0x80; 40 words in order.
- 4 KB crossing: addr=0xFF8, length=6 -> AR araddr=0xFF8 arlen=1, then araddr=0x1000 arlen=3.
- Backpressure: m_iob_ready toggling 1/0 randomly during a length=20 transfer -> all 20 words delivered exactly once, in order; rready=0 whenever the buffer is full.
- Errors: SLVERR on beat 2 of 4 -> error_o=1 at completion; next run with clean data -> error_o=0. Missing rlast on the final beat -> error_o=1, no hang.
- Edge/control: length=0 -> ready_o stays 1, no AR. run_i pulsed while busy -> ignored. rst_i asserted in DATA -> ready_o=1, arvalid=0, m_iob_valid_o=0 the same cycle.
